tempsense_supervisor: RTL and testbench



---
 rtl/tempsense_supervisor.sv | 244 ++++++++++++++++++++++++
 tb/tb_tempsense_supervisor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tempsense_supervisor.sv
// tempsense_supervisor
// Boot-delay and fan supervisor driven by a sampled temperature sensor.
// After EN rises the block waits a fixed delay (modes 00/01/10) or reads the
// sensor and derives a temperature-dependent delay (mode 11). When the delay
// ends, BOOT_READY rises and the block samples the sensor periodically to
// drive the fan with hysteresis.
//
// Ports:
//   MCLK, RESET            clock, synchronous active-high reset
//   EN                     block enable; low clears everything like RESET
//   SETTING[2:0]           [2] manual fan allowed, [1:0] delay mode
//   PUSHSW                 force boot during a delay / manual fan after boot
//   TL_LOAD                one-cycle sensor read request
//   TL_DONE/VALID/TEMP     sensor read completion, valid flag, signed temp
//   BOOT_READY             startup delay finished
//   FAN_EN                 fan drive
//   DLY_REMAIN             seconds left in the current delay, else 0
//   REPORT_VALID           pulse when a computed delay is latched
//   REPORT_TEMP/REPORT_DLY temperature and delay of the last report
module tempsense_supervisor #(
  parameter int CLK_PER_SEC  = 48000000,
  parameter int TEMP_W       = 13,
  parameter int DLY_W        = 12,
  parameter int CHECK_PERIOD = 20,
  parameter int FAN_ON_T     = 608,
  parameter int FAN_OFF_T    = 560,
  parameter int SKIP_T       = 432,
  parameter int SLOPE_Q4     = 269,
  parameter int OFFSET       = 484,
  parameter int NEG_RETRY    = 1
) (
  input  logic                     MCLK,
  input  logic                     RESET,
  input  logic                     EN,
  input  logic [2:0]               SETTING,
  input  logic                     PUSHSW,
  output logic                     TL_LOAD,
  input  logic                     TL_DONE,
  input  logic                     TL_VALID,
  input  logic signed [TEMP_W-1:0] TL_TEMP,
  output logic                     BOOT_READY,
  output logic                     FAN_EN,
  output logic [DLY_W-1:0]         DLY_REMAIN,
  output logic                     REPORT_VALID,
  output logic signed [TEMP_W-1:0] REPORT_TEMP,
  output logic [DLY_W-1:0]         REPORT_DLY
);

  localparam int PSC_W = $clog2(CLK_PER_SEC + 1);
  localparam int RTY_W = $clog2(NEG_RETRY + 2);
  localparam int CW    = TEMP_W + DLY_W + 12;

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_PER_SEC - 1);
  localparam logic [DLY_W-1:0] CHECK_C  = DLY_W'(CHECK_PERIOD);
  localparam logic [RTY_W-1:0] RETRY_C  = RTY_W'(NEG_RETRY);
  localparam logic signed [TEMP_W-1:0] SKIP_C    = TEMP_W'(SKIP_T);
  localparam logic signed [TEMP_W-1:0] FAN_ON_C  = TEMP_W'(FAN_ON_T);
  localparam logic signed [TEMP_W-1:0] FAN_OFF_C = TEMP_W'(FAN_OFF_T);
  localparam logic signed [CW-1:0] SLOPE_C  = CW'(SLOPE_Q4);
  localparam logic signed [CW-1:0] OFFSET_C = CW'(OFFSET) <<< 8;
  localparam logic signed [CW-1:0] DMAX_C   = {{(CW-DLY_W){1'b0}}, {DLY_W{1'b1}}};

  typedef enum logic [3:0] {
    IDLE, FIX_WAIT, SMP_REQ, SMP_WAIT, SMP_RETRY,
    COMPUTE, DLY_WAIT, RUN_WAIT, RUN_REQ, RUN_SMP
  } state_t;

  state_t                   state_q, state_d;
  logic [PSC_W-1:0]         psc_q, psc_d;
  logic [DLY_W-1:0]         sec_q, sec_d;
  logic [DLY_W-1:0]         dly_q, dly_d;
  logic [RTY_W-1:0]         retry_q, retry_d;
  logic signed [TEMP_W-1:0] temp_q, temp_d;
  logic                     manual_q, manual_d;
  logic                     fan_hot_q, fan_hot_d;
  logic                     fan_en_q, fan_en_d;
  logic                     boot_q, boot_d;
  logic                     report_valid_q, report_valid_d;
  logic signed [TEMP_W-1:0] report_temp_q, report_temp_d;
  logic [DLY_W-1:0]         report_dly_q, report_dly_d;

  logic                     tick;
  logic [DLY_W-1:0]         sec_inc;
  logic signed [CW-1:0]     dly_full;
  logic [DLY_W-1:0]         dly_clamped;

  assign tick    = (psc_q == PSC_LAST);
  assign sec_inc = sec_q + 1'b1;

  // Delay from temperature in Q8: floor((OFFSET*256 - T*SLOPE_Q4) / 256).
  // The arithmetic shift of a signed value gives floor for negatives too.
  always_comb begin
    dly_full = ((OFFSET_C - (CW'(temp_q) * SLOPE_C)) >>> 8);
    if (dly_full[CW-1]) begin
      dly_clamped = '0;
    end else if (dly_full > DMAX_C) begin
      dly_clamped = '1;
    end else begin
      dly_clamped = dly_full[DLY_W-1:0];
    end
  end

  // Next-state and register updates. Every state change restarts the
  // prescaler and seconds counter, so each wait state counts from zero.
  always_comb begin
    state_d        = state_q;
    dly_d          = dly_q;
    retry_d        = retry_q;
    temp_d         = temp_q;
    manual_d       = manual_q;
    fan_hot_d      = fan_hot_q;
    report_valid_d = 1'b0;
    report_temp_d  = report_temp_q;
    report_dly_d   = report_dly_q;

    case (state_q)
      IDLE: begin
        if (EN) begin
          manual_d = SETTING[2];
          case (SETTING[1:0])
            2'b00:   begin dly_d = DLY_W'(1);   state_d = FIX_WAIT; end
            2'b01:   begin dly_d = DLY_W'(80);  state_d = FIX_WAIT; end
            2'b10:   begin dly_d = DLY_W'(260); state_d = FIX_WAIT; end
            default: state_d = SMP_REQ;
          endcase
        end
      end
      FIX_WAIT, DLY_WAIT: begin
        if (PUSHSW || (dly_q == '0) || (tick && (sec_inc == dly_q))) begin
          state_d = RUN_WAIT;
        end
      end
      SMP_REQ: state_d = SMP_WAIT;
      SMP_WAIT: begin
        if (TL_DONE) begin
          if (!TL_VALID) begin
            state_d = SMP_RETRY;
          end else if (TL_TEMP[TEMP_W-1] && (retry_q < RETRY_C)) begin
            retry_d = retry_q + 1'b1;
            state_d = SMP_RETRY;
          end else if (TL_TEMP > SKIP_C) begin
            state_d = RUN_WAIT;
          end else begin
            temp_d  = TL_TEMP;
            state_d = COMPUTE;
          end
        end else if (tick && (sec_inc == DLY_W'(2))) begin
          state_d = SMP_RETRY;
        end
      end
      SMP_RETRY: begin
        if (tick && (sec_inc == DLY_W'(1))) begin
          state_d = SMP_REQ;
        end
      end
      COMPUTE: begin
        dly_d          = dly_clamped;
        report_valid_d = 1'b1;
        report_temp_d  = temp_q;
        report_dly_d   = dly_clamped;
        state_d        = DLY_WAIT;
      end
      RUN_WAIT: begin
        if (tick && (sec_inc == CHECK_C)) begin
          state_d = RUN_REQ;
        end
      end
      RUN_REQ: state_d = RUN_SMP;
      RUN_SMP: begin
        if (TL_DONE) begin
          if (TL_VALID) begin
            if (TL_TEMP >= FAN_ON_C) begin
              fan_hot_d = 1'b1;
            end else if (TL_TEMP <= FAN_OFF_C) begin
              fan_hot_d = 1'b0;
            end
          end
          state_d = RUN_WAIT;
        end else if (tick && (sec_inc == DLY_W'(2))) begin
          state_d = RUN_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    boot_d   = boot_q | (state_d == RUN_WAIT);
    fan_en_d = fan_hot_q | (manual_q & PUSHSW & boot_q);
  end

  // Prescaler and seconds counter.
  always_comb begin
    psc_d = psc_q + 1'b1;
    sec_d = sec_q;
    if (state_d != state_q) begin
      psc_d = '0;
      sec_d = '0;
    end else if (tick) begin
      psc_d = '0;
      sec_d = sec_inc;
    end
  end

  // EN low clears the block exactly like RESET.
  always_ff @(posedge MCLK) begin
    if (RESET || !EN) begin
      state_q        <= IDLE;
      psc_q          <= '0;
      sec_q          <= '0;
      dly_q          <= '0;
      retry_q        <= '0;
      temp_q         <= '0;
      manual_q       <= 1'b0;
      fan_hot_q      <= 1'b0;
      fan_en_q       <= 1'b0;
      boot_q         <= 1'b0;
      report_valid_q <= 1'b0;
      report_temp_q  <= '0;
      report_dly_q   <= '0;
    end else begin
      state_q        <= state_d;
      psc_q          <= psc_d;
      sec_q          <= sec_d;
      dly_q          <= dly_d;
      retry_q        <= retry_d;
      temp_q         <= temp_d;
      manual_q       <= manual_d;
      fan_hot_q      <= fan_hot_d;
      fan_en_q       <= fan_en_d;
      boot_q         <= boot_d;
      report_valid_q <= report_valid_d;
      report_temp_q  <= report_temp_d;
      report_dly_q   <= report_dly_d;
    end
  end

  assign TL_LOAD      = (state_q == SMP_REQ) || (state_q == RUN_REQ);
  assign BOOT_READY   = boot_q;
  assign FAN_EN       = fan_en_q;
  assign DLY_REMAIN   = ((state_q == FIX_WAIT) || (state_q == DLY_WAIT)) ? (dly_q - sec_q) : '0;
  assign REPORT_VALID = report_valid_q;
  assign REPORT_TEMP  = report_temp_q;
  assign REPORT_DLY   = report_dly_q;

endmodule

// File: tb/tb_tempsense_supervisor.sv
// tb_tempsense_supervisor
// Directed bench for tempsense_supervisor with a 10-cycle second. A second
// instance with OFFSET=5000 covers the upper clamp of the computed delay.
module tb_tempsense_supervisor;

  logic               mclk = 1'b0;
  logic               reset, en, en_b, pushsw, tl_done, tl_valid;
  logic [2:0]         setting;
  logic signed [12:0] tl_temp;

  logic               tl_load, boot_ready, fan_en, report_valid;
  logic [11:0]        dly_remain, report_dly;
  logic signed [12:0] report_temp;

  logic               tl_load_b, boot_ready_b, fan_en_b, report_valid_b;
  logic [11:0]        dly_remain_b, report_dly_b;
  logic signed [12:0] report_temp_b;

  int vectors = 0;
  int miscompares = 0;
  int load_count = 0;
  int rv_count = 0;

  tempsense_supervisor #(.CLK_PER_SEC(10)) u_dut (
    .MCLK(mclk), .RESET(reset), .EN(en), .SETTING(setting), .PUSHSW(pushsw),
    .TL_LOAD(tl_load), .TL_DONE(tl_done), .TL_VALID(tl_valid), .TL_TEMP(tl_temp),
    .BOOT_READY(boot_ready), .FAN_EN(fan_en), .DLY_REMAIN(dly_remain),
    .REPORT_VALID(report_valid), .REPORT_TEMP(report_temp), .REPORT_DLY(report_dly)
  );

  tempsense_supervisor #(.CLK_PER_SEC(10), .OFFSET(5000)) u_dut_ofs (
    .MCLK(mclk), .RESET(reset), .EN(en_b), .SETTING(setting), .PUSHSW(pushsw),
    .TL_LOAD(tl_load_b), .TL_DONE(tl_done), .TL_VALID(tl_valid), .TL_TEMP(tl_temp),
    .BOOT_READY(boot_ready_b), .FAN_EN(fan_en_b), .DLY_REMAIN(dly_remain_b),
    .REPORT_VALID(report_valid_b), .REPORT_TEMP(report_temp_b), .REPORT_DLY(report_dly_b)
  );

  always #5 mclk = ~mclk;

  // Pulse counters for the main instance, sampled on the active edge so the
  // negedge-driven sequence can read them without racing.
  always @(posedge mclk) begin
    if (tl_load) load_count <= load_count + 1;
    if (report_valid) rv_count <= rv_count + 1;
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic doReset();
    reset = 1'b1; en = 1'b0; en_b = 1'b0; pushsw = 1'b0;
    tl_done = 1'b0; tl_valid = 1'b0; tl_temp = '0; setting = '0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(1);
  endtask

  task automatic waitLoad();
    int n = 0;
    while (!(tl_load || tl_load_b) && n < 400) begin
      @(negedge mclk);
      n++;
    end
    checkOutput("tl_load_seen", int'(tl_load || tl_load_b), 1);
  endtask

  // Waits for a read request, then answers it on the following cycle.
  task automatic applyStimulus(input logic signed [12:0] temp, input logic valid);
    waitLoad();
    @(negedge mclk);
    tl_done = 1'b1; tl_valid = valid; tl_temp = temp;
    @(negedge mclk);
    tl_done = 1'b0; tl_valid = 1'b0;
  endtask

  task automatic waitReport();
    int n = 0;
    while (!(report_valid || report_valid_b) && n < 10) begin
      @(negedge mclk);
      n++;
    end
    checkOutput("report_valid_seen", int'(report_valid || report_valid_b), 1);
  endtask

  task automatic waitBoot(input int maxc, output int n);
    n = 0;
    while (!boot_ready && n < maxc) begin
      @(negedge mclk);
      n++;
    end
  endtask

  initial begin
    int n;
    int base_load;
    int base_rv;
    doReset();

    $display("[TB] reset values");
    checkOutput("rst_tl_load", int'(tl_load), 0);
    checkOutput("rst_boot", int'(boot_ready), 0);
    checkOutput("rst_fan", int'(fan_en), 0);
    checkOutput("rst_dly_remain", int'(dly_remain), 0);
    checkOutput("rst_report_valid", int'(report_valid), 0);
    checkOutput("rst_report_temp", int'(report_temp), 0);
    checkOutput("rst_report_dly", int'(report_dly), 0);

    $display("[TB] mode 01 fixed 80 s delay");
    setting = 3'b001; en = 1'b1;
    waitCycles(1);
    checkOutput("m01_remain_start", int'(dly_remain), 80);
    waitCycles(10);
    checkOutput("m01_remain_1s", int'(dly_remain), 79);
    waitBoot(900, n);
    n += 11;
    checkOutput($sformatf("m01_boot_time n=%0d", n), int'(n >= 798 && n <= 802), 1);
    checkOutput("m01_remain_after", int'(dly_remain), 0);

    $display("[TB] fan hysteresis on run samples");
    applyStimulus(13'sd600, 1'b1); waitCycles(2);
    checkOutput("fan_600", int'(fan_en), 0);
    applyStimulus(13'sd608, 1'b1); waitCycles(2);
    checkOutput("fan_608", int'(fan_en), 1);
    applyStimulus(13'sd580, 1'b1); waitCycles(2);
    checkOutput("fan_580", int'(fan_en), 1);
    applyStimulus(13'sd560, 1'b1); waitCycles(2);
    checkOutput("fan_560", int'(fan_en), 0);
    applyStimulus(13'sd700, 1'b1); waitCycles(2);
    checkOutput("fan_700", int'(fan_en), 1);
    waitLoad();
    waitCycles(30);
    checkOutput("fan_timeout_hold", int'(fan_en), 1);
    applyStimulus(13'sd500, 1'b1); waitCycles(2);
    checkOutput("fan_500_after_timeout", int'(fan_en), 0);

    $display("[TB] manual fan after 1 s boot");
    doReset();
    setting = 3'b100; en = 1'b1;
    waitBoot(40, n);
    checkOutput("man_boot", int'(boot_ready), 1);
    waitCycles(1);
    checkOutput("man_fan_idle", int'(fan_en), 0);
    pushsw = 1'b1; waitCycles(2);
    checkOutput("man_fan_push", int'(fan_en), 1);
    pushsw = 1'b0; waitCycles(2);
    checkOutput("man_fan_release", int'(fan_en), 0);

    $display("[TB] mode 11 at 20.0 degC");
    doReset();
    setting = 3'b011; en = 1'b1;
    applyStimulus(13'sd320, 1'b1);
    waitReport();
    checkOutput("t320_report_dly", int'(report_dly), 147);
    checkOutput("t320_report_temp", int'(report_temp), 320);
    checkOutput("t320_remain", int'(dly_remain), 147);
    waitBoot(1600, n);
    checkOutput($sformatf("t320_boot_time n=%0d", n), int'(n >= 1468 && n <= 1472), 1);

    $display("[TB] negative reading with one retry, then push to boot");
    doReset();
    base_load = load_count;
    setting = 3'b011; en = 1'b1;
    applyStimulus(-13'sd80, 1'b1);
    applyStimulus(-13'sd80, 1'b1);
    waitReport();
    checkOutput("neg_report_dly", int'(report_dly), 568);
    checkOutput("neg_load_count", load_count - base_load, 2);
    checkOutput("neg_boot_before_push", int'(boot_ready), 0);
    pushsw = 1'b1; waitCycles(1);
    checkOutput("neg_boot_push", int'(boot_ready), 1);
    pushsw = 1'b0;

    $display("[TB] EN low clears, then reset during a read");
    en = 1'b0; waitCycles(1);
    checkOutput("enlow_report_dly", int'(report_dly), 0);
    checkOutput("enlow_boot", int'(boot_ready), 0);
    en = 1'b1;
    waitLoad();
    waitCycles(3);
    reset = 1'b1; waitCycles(1);
    checkOutput("midrst_tl_load", int'(tl_load), 0);
    checkOutput("midrst_boot", int'(boot_ready), 0);
    checkOutput("midrst_remain", int'(dly_remain), 0);
    checkOutput("midrst_report_valid", int'(report_valid), 0);
    en = 1'b0; reset = 1'b0;
    base_rv = rv_count;
    waitCycles(1);
    tl_done = 1'b1; tl_valid = 1'b1; tl_temp = 13'sd448;
    waitCycles(1);
    tl_done = 1'b0; tl_valid = 1'b0;
    waitCycles(3);
    checkOutput("late_done_boot", int'(boot_ready), 0);
    checkOutput("late_done_report", rv_count - base_rv, 0);

    $display("[TB] invalid read then warm read skips the delay");
    doReset();
    base_load = load_count;
    base_rv = rv_count;
    setting = 3'b011; en = 1'b1;
    applyStimulus(13'sd0, 1'b0);
    applyStimulus(13'sd448, 1'b1);
    waitCycles(2);
    checkOutput("skip_boot", int'(boot_ready), 1);
    checkOutput("skip_no_report", rv_count - base_rv, 0);
    checkOutput("skip_load_count", load_count - base_load, 2);

    $display("[TB] clamp with OFFSET=5000");
    doReset();
    setting = 3'b011; en_b = 1'b1;
    applyStimulus(13'sd0, 1'b1);
    waitReport();
    checkOutput("clamp_report_dly", int'(report_dly_b), 4095);
    checkOutput("clamp_report_temp", int'(report_temp_b), 0);
    checkOutput("clamp_remain", int'(dly_remain_b), 4095);
    en_b = 1'b0;
    waitCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
